note_uart_tx: RTL and testbench



---
 rtl/note_pkg.sv | 33 +++
 rtl/note_uart_tx_if.sv | 22 ++
 rtl/note_fifo.sv | 65 ++++++
 rtl/note_uart_tx.sv | 156 +++++++++++++++
 tb/tb_note_uart_tx.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/note_pkg.sv
// Shared types and constants for the note UART transmitter.
// NOTE_TX_PARITY_EN adds the PARITY state to the frame encoding.
package note_pkg;

    localparam int NOTE_W   = 8;
    localparam int TONE_MSB = 7;
    localparam int TONE_LSB = 3;
    localparam int DUR_MSB  = 2;
    localparam int DUR_LSB  = 0;

    typedef logic [DUR_MSB-DUR_LSB:0] dur_t;

    localparam dur_t DUR_QUARTER = 3'd1;
    localparam dur_t DUR_HALF    = 3'd2;
    localparam dur_t DUR_ONE     = 3'd3;
    localparam dur_t DUR_TWO     = 3'd4;
    localparam dur_t DUR_FOUR    = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef NOTE_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_e;

    function automatic logic dur_is_valid(input logic [NOTE_W-1:0] code);
        return (code[DUR_MSB:DUR_LSB] >= DUR_QUARTER) && (code[DUR_MSB:DUR_LSB] <= DUR_FOUR);
    endfunction

endpackage

// File: rtl/note_uart_tx_if.sv
// Note write channel between a producer and the transmitter.
// Unaffected by NOTE_TX_PARITY_EN.
interface note_uart_tx_if;
    logic       note_valid;
    logic [7:0] note_data;
    logic       note_ready;
    logic       note_err;

    modport master (
        output note_valid,
        output note_data,
        input  note_ready,
        input  note_err
    );

    modport slave (
        input  note_valid,
        input  note_data,
        output note_ready,
        output note_err
    );
endinterface

// File: rtl/note_fifo.sv
// Count-based synchronous note queue with registered full/empty flags.
// Unaffected by NOTE_TX_PARITY_EN.
module note_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok, pop_ok;

    // A push while full is dropped even if a pop happens in the same cycle.
    always_comb begin
        push_ok  = push_i && !full_q;
        pop_ok   = pop_i && !empty_q;
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        full_d   = (count_d == DEPTH_C);
        empty_d  = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // NOTE: storage is not reset; validity is tracked by count and pointers alone.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
endmodule

// File: rtl/note_uart_tx.sv
// Note queue feeding an 8N1 UART transmitter; frames run back-to-back while notes wait.
// NOTE_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module note_uart_tx
    import note_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    note_uart_tx_if.slave note,
    output logic          uart_txd,
    output logic          tx_done_flag,
    output logic          tx_busy
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

    tx_state_e        state_q, state_d;
    logic [CW-1:0]    baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [NOTE_W-1:0] shift_q, shift_d;
    logic             err_q, err_d;
`ifdef NOTE_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic              push, pop, full, empty, bit_end;
    logic [NOTE_W-1:0] head;

    assign push  = note.note_valid && dur_is_valid(note.note_data) && !full;
    assign err_d = note.note_valid && (!dur_is_valid(note.note_data) || full);

    note_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (NOTE_W)
    ) u_fifo (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .push_i  (push),
        .data_i  (note.note_data),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign bit_end = (baud_q == BAUD_LAST);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q + CW'(1);
        bit_d        = bit_q;
        shift_d      = shift_q;
        pop          = 1'b0;
        uart_txd     = 1'b1;
        tx_done_flag = 1'b0;
`ifdef NOTE_TX_PARITY_EN
        parity_d     = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                uart_txd = 1'b0;
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                uart_txd = shift_q[0];
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef NOTE_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef NOTE_TX_PARITY_EN
            ST_PARITY: begin
                uart_txd = parity_q;
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    baud_d       = '0;
                    tx_done_flag = 1'b1;
                    // Chain straight into the next frame when a note is waiting.
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = ST_IDLE;
            end
        endcase

        if (pop) begin
            shift_d = head;
            bit_d   = 3'd0;
`ifdef NOTE_TX_PARITY_EN
            parity_d = ^head;
`endif
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            err_q    <= 1'b0;
`ifdef NOTE_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            err_q    <= err_d;
`ifdef NOTE_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign note.note_ready = !full;
    assign note.note_err   = err_q;
    assign tx_busy         = (state_q != ST_IDLE) || !empty;
endmodule

// File: tb/tb_note_uart_tx.sv
// Self-checking bench for note_uart_tx at DIV=10; define NOTE_TX_PARITY_EN to test the parity build.
// A transaction-level model predicts every sampled output cycle from the accepted notes.
module tb_note_uart_tx;
    import note_pkg::*;

    localparam int CLK_FREQ   = 1_000_000;
    localparam int BAUD       = 100_000;
    localparam int FIFO_DEPTH = 4;
    localparam int DIV        = 10;
`ifdef NOTE_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam bit PARITY     = 1'b1;
`else
    localparam int FRAME_BITS = 10;
    localparam bit PARITY     = 1'b0;
`endif
    localparam int FL   = FRAME_BITS * DIV;
    localparam int MAXL = 1200;
    localparam int MAXW = 16;

    logic sys_clk = 1'b0;
    logic sys_rst;
    logic uart_txd, tx_done_flag, tx_busy;

    note_uart_tx_if note_bus ();

    note_uart_tx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .note         (note_bus),
        .uart_txd     (uart_txd),
        .tx_done_flag (tx_done_flag),
        .tx_busy      (tx_busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic txd;
        logic done;
        logic err;
        logic busy;
        logic ready;
    } sample_t;

    // One sample per falling edge, far from the rising edge where the DUT updates.
    sample_t hist[$];
    always @(negedge sys_clk) begin
        hist.push_back({uart_txd, tx_done_flag, note_bus.note_err, tx_busy, note_bus.note_ready});
    end

    int          checks = 0;
    int          errors = 0;
    logic        stim_valid [MAXW];
    logic [7:0]  stim_code  [MAXW];
    sample_t     exp_trace  [MAXL];
    int          scen_start;
    int          scen_mism;
    string       scen_first;

    function automatic logic frame_bit(input logic [7:0] code, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return code[b-1];
        if (PARITY && b == 9) return ^code;
        return 1'b1;
    endfunction

    function automatic bit dur_ok(input logic [7:0] code);
        int d;
        d = int'(code) % 8;
        return (d >= 1) && (d <= 5);
    endfunction

    function automatic logic [7:0] rand_valid_code();
        logic [7:0] c;
        c = '0;
        c[TONE_MSB:TONE_LSB] = 5'($urandom_range(0, 31));
        c[DUR_MSB:DUR_LSB]   = 3'($urandom_range(1, 5));
        return c;
    endfunction

    // Drives stim_* on consecutive cycles, predicts len samples and compares them.
    task automatic run_scenario(input int n, input int len);
        logic [7:0] q[$];
        logic [7:0] code;
        int         frame_end;
        int         pre;
        bit         acc;
        int         s;
        frame_end = -1;
        for (int i = 0; i < len; i++) begin
            exp_trace[i] = '{txd: 1'b1, done: 1'b0, err: 1'b0, busy: 1'b0, ready: 1'b1};
        end
        for (int k = 0; k < len - 1; k++) begin
            pre = q.size();
            acc = 1'b0;
            if (k < n && stim_valid[k]) begin
                if (!dur_ok(stim_code[k]) || pre == FIFO_DEPTH) exp_trace[k+1].err = 1'b1;
                else acc = 1'b1;
            end
            if (frame_end <= k && pre > 0) begin
                code = q.pop_front();
                for (int j = 0; j < FL; j++) begin
                    if (k + 1 + j < len) begin
                        exp_trace[k+1+j].txd  = frame_bit(code, j / DIV);
                        exp_trace[k+1+j].busy = 1'b1;
                        exp_trace[k+1+j].done = (j == FL - 1);
                    end
                end
                frame_end = k + FL;
            end
            if (acc) q.push_back(stim_code[k]);
            if (q.size() > 0) exp_trace[k+1].busy = 1'b1;
            exp_trace[k+1].ready = (q.size() < FIFO_DEPTH);
        end

        s = 0;
        for (int i = 0; i < len; i++) begin
            @(posedge sys_clk);
            #1;
            if (i == 0) s = hist.size();
            note_bus.note_valid = (i < n) ? stim_valid[i] : 1'b0;
            note_bus.note_data  = (i < n) ? stim_code[i] : 8'h00;
        end
        @(negedge sys_clk);
        #1;

        scen_start = s;
        scen_mism  = 0;
        scen_first = "";
        for (int i = 0; i < len; i++) begin
            if (hist[s+i] !== exp_trace[i]) begin
                if (scen_mism == 0)
                    scen_first = $sformatf("cycle %0d got %b expected %b (txd,done,err,busy,ready)",
                                           i, hist[s+i], exp_trace[i]);
                scen_mism++;
            end
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        note_bus.note_valid = 1'b0;
        note_bus.note_data  = 8'h00;
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (uart_txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", uart_txd); end
        checks++;
        if (note_bus.note_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", note_bus.note_ready); end
        checks++;
        if (note_bus.note_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", note_bus.note_err); end
        checks++;
        if (tx_done_flag !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", tx_done_flag); end
        checks++;
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
    endtask

    task automatic test_single_frame();
        int exp_bits [8] = '{1, 0, 0, 0, 1, 1, 0, 0};
        int lows, dones, bad_bits;
        stim_valid[0] = 1'b1;
        stim_code[0]  = 8'h31;
        run_scenario(1, FL + 12);
        checks++;
        if (scen_mism !== 0) begin errors++; $display("FAIL single_frame_trace: %0d bad cycles, first %s", scen_mism, scen_first); end

        lows = 0;
        for (int i = 2; i < FL && hist[scen_start+i].txd === 1'b0; i++) lows++;
        checks++;
        if (lows !== DIV) begin errors++; $display("FAIL single_frame_start_len: got %0d low cycles expected %0d", lows, DIV); end

        bad_bits = 0;
        for (int b = 0; b < 8; b++)
            if (hist[scen_start + 2 + DIV*(b+1) + DIV/2].txd !== 1'(exp_bits[b])) bad_bits++;
        checks++;
        if (bad_bits !== 0) begin errors++; $display("FAIL single_frame_data_bits: got %0d wrong bits expected 0", bad_bits); end

`ifdef NOTE_TX_PARITY_EN
        checks++;
        if (hist[scen_start + 2 + 9*DIV + DIV/2].txd !== 1'b1) begin
            errors++; $display("FAIL single_frame_parity: got %b expected 1", hist[scen_start + 2 + 9*DIV + DIV/2].txd);
        end
`endif

        dones = 0;
        for (int i = 0; i < FL + 12; i++) if (hist[scen_start+i].done === 1'b1) dones++;
        checks++;
        if (dones !== 1 || hist[scen_start + FL + 1].done !== 1'b1) begin
            errors++; $display("FAIL single_frame_done: got %0d pulses (at frame end %b) expected 1 at cycle %0d",
                               dones, hist[scen_start + FL + 1].done, FL + 1);
        end
    endtask

    task automatic test_bad_duration();
        int errs, busy_hi, txd_lo;
        stim_valid[0] = 1'b1; stim_code[0] = 8'h30;
        stim_valid[1] = 1'b1; stim_code[1] = 8'h37;
        run_scenario(2, 20);
        checks++;
        if (scen_mism !== 0) begin errors++; $display("FAIL bad_dur_trace: %0d bad cycles, first %s", scen_mism, scen_first); end
        errs = 0; busy_hi = 0; txd_lo = 0;
        for (int i = 0; i < 20; i++) begin
            if (hist[scen_start+i].err === 1'b1) errs++;
            if (hist[scen_start+i].busy !== 1'b0) busy_hi++;
            if (hist[scen_start+i].txd !== 1'b1) txd_lo++;
        end
        checks++;
        if (errs !== 2 || busy_hi !== 0 || txd_lo !== 0) begin
            errors++; $display("FAIL bad_dur_summary: got err=%0d busy=%0d txd_low=%0d expected 2/0/0", errs, busy_hi, txd_lo);
        end
    endtask

    task automatic test_back_to_back();
        int done_idx[$];
        int busy_gap;
        for (int i = 0; i < 8; i++) begin
            stim_valid[i] = !(i == 1 || i == 2);
            stim_code[i]  = rand_valid_code();
        end
        run_scenario(8, 5*FL + 20);
        checks++;
        if (scen_mism !== 0) begin errors++; $display("FAIL back_to_back_trace: %0d bad cycles, first %s", scen_mism, scen_first); end
        checks++;
        if (hist[scen_start+7].ready !== 1'b0) begin errors++; $display("FAIL overflow_ready: got %b expected 0", hist[scen_start+7].ready); end
        checks++;
        if (hist[scen_start+8].err !== 1'b1) begin errors++; $display("FAIL overflow_err: got %b expected 1", hist[scen_start+8].err); end

        for (int i = 0; i < 5*FL + 20; i++) if (hist[scen_start+i].done === 1'b1) done_idx.push_back(i);
        busy_gap = 0;
        for (int i = 2; i < 2 + 5*FL; i++) if (hist[scen_start+i].busy !== 1'b1) busy_gap++;
        checks++;
        if (done_idx.size() !== 5 || busy_gap !== 0 || (done_idx.size() == 5 && done_idx[4] - done_idx[0] !== 4*FL)) begin
            errors++; $display("FAIL back_to_back_frames: got %0d frames, %0d idle cycles expected 5 contiguous",
                               done_idx.size(), busy_gap);
        end
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                stim_valid[i] = ($urandom_range(0, 3) != 0);
                stim_code[i]  = 8'($urandom);
            end
            run_scenario(n, n + (n + 1)*FL + 10);
            checks++;
            if (scen_mism !== 0) begin errors++; $display("FAIL random_%0d_trace: %0d bad cycles, first %s", it, scen_mism, scen_first); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int s, dones, txd_lo;
        @(posedge sys_clk);
        #1;
        s = hist.size();
        note_bus.note_valid = 1'b1;
        note_bus.note_data  = 8'h31;
        @(posedge sys_clk);
        #1;
        note_bus.note_valid = 1'b0;
        repeat (44) @(posedge sys_clk);
        #1;
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        repeat (150) @(posedge sys_clk);
        @(negedge sys_clk);
        #1;
        checks++;
        if (hist[s+45].txd !== 1'b0 || hist[s+45].busy !== 1'b1) begin
            errors++; $display("FAIL midreset_in_bit3: got txd=%b busy=%b expected 0/1", hist[s+45].txd, hist[s+45].busy);
        end
        checks++;
        if (hist[s+46] !== sample_t'(5'b10001)) begin
            errors++; $display("FAIL midreset_after: got %b expected 10001 (txd,done,err,busy,ready)", hist[s+46]);
        end
        dones = 0; txd_lo = 0;
        for (int i = 0; i < 190; i++) if (hist[s+i].done === 1'b1) dones++;
        for (int i = 46; i < 190; i++) if (hist[s+i].txd !== 1'b1) txd_lo++;
        checks++;
        if (dones !== 0 || txd_lo !== 0) begin
            errors++; $display("FAIL midreset_quiet: got done=%0d txd_low=%0d expected 0/0", dones, txd_lo);
        end
        stim_valid[0] = 1'b1;
        stim_code[0]  = rand_valid_code();
        run_scenario(1, FL + 12);
        checks++;
        if (scen_mism !== 0) begin errors++; $display("FAIL midreset_recover_trace: %0d bad cycles, first %s", scen_mism, scen_first); end
    endtask

    initial begin
        sys_rst = 1'b1;
        note_bus.note_valid = 1'b0;
        note_bus.note_data  = 8'h00;
        test_reset();
        test_single_frame();
        test_bad_duration();
        test_back_to_back();
        test_random();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
